dnc_matrix_streamer: RTL and testbench

- Upstream feeder for the DNC accelerator top.
- Walks an L x X operand matrix (W, K or U class) held in a local source memory, one element at a time.
- Presents each element on the accelerator's DATA_IN with row (L) and column (X) enable strobes, and waits for the accelerator's per-element OUT enable before advancing.
- Replaces bench-driven stimulus with synthesizable sequencing.

---
 rtl/dnc_matrix_streamer_pkg.sv | 22 ++
 rtl/dnc_matrix_streamer_counter.sv | 130 +++++++++++++
 rtl/dnc_matrix_streamer.sv | 206 ++++++++++++++++++++
 tb/tb_dnc_matrix_streamer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dnc_matrix_streamer_pkg.sv
// ----------------------------------------------------------------------------
// dnc_matrix_streamer_pkg
// Shared definitions for the DNC matrix streamer:
//   - default widths for matrix elements, counters and source addresses
//   - the sequencing FSM state encoding
// ----------------------------------------------------------------------------
package dnc_matrix_streamer_pkg;

  localparam int DNC_DATA_SIZE    = 64;
  localparam int DNC_CONTROL_SIZE = 64;
  localparam int DNC_ADDRESS_SIZE = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_WAIT_ACK  = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

endpackage

// File: rtl/dnc_matrix_streamer_counter.sv
// ----------------------------------------------------------------------------
// dnc_matrix_streamer_counter
// Two-level nested counter that walks a matrix and produces the source
// address of the current element without a multiplier. The address is
// base + offset, where offset grows by inner_stride per inner step and base
// grows by outer_stride per outer step (offset returns to 0).
//   Row-major:    inner_stride = 1,      outer_stride = SIZE_X
//   Column-major: inner_stride = SIZE_X, outer_stride = 1
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clear               load sizes/strides and restart at element 0
//   step                advance to the next element
//   size_inner/outer    loop bounds (sampled on clear)
//   inner/outer_stride  address increments (sampled on clear)
//   inner, outer        current loop indices
//   address             current source address (registered, wraps)
//   last_inner          current element ends an inner run
//   last_element        current element is the final one
// ----------------------------------------------------------------------------
module dnc_matrix_streamer_counter
  import dnc_matrix_streamer_pkg::*;
#(
  parameter int CONTROL_SIZE = DNC_CONTROL_SIZE,
  parameter int ADDRESS_SIZE = DNC_ADDRESS_SIZE
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    step,
  input  logic [CONTROL_SIZE-1:0] size_inner,
  input  logic [CONTROL_SIZE-1:0] size_outer,
  input  logic [CONTROL_SIZE-1:0] inner_stride,
  input  logic [CONTROL_SIZE-1:0] outer_stride,
  output logic [CONTROL_SIZE-1:0] inner,
  output logic [CONTROL_SIZE-1:0] outer,
  output logic [ADDRESS_SIZE-1:0] address,
  output logic                    last_inner,
  output logic                    last_element
);

  localparam logic [CONTROL_SIZE-1:0] CNT_ZERO = {CONTROL_SIZE{1'b0}};
  localparam logic [CONTROL_SIZE-1:0] CNT_ONE  = CONTROL_SIZE'(1'b1);

  logic [CONTROL_SIZE-1:0] inner_q, inner_d;
  logic [CONTROL_SIZE-1:0] outer_q, outer_d;
  logic [CONTROL_SIZE-1:0] base_q, base_d;
  logic [CONTROL_SIZE-1:0] offset_q, offset_d;
  logic [CONTROL_SIZE-1:0] size_inner_q, size_inner_d;
  logic [CONTROL_SIZE-1:0] size_outer_q, size_outer_d;
  logic [CONTROL_SIZE-1:0] inner_stride_q, inner_stride_d;
  logic [CONTROL_SIZE-1:0] outer_stride_q, outer_stride_d;
  logic [ADDRESS_SIZE-1:0] address_q, address_d;
  logic                    last_inner_s;
  logic                    last_outer_s;

  // End-of-run detection against the latched bounds
  always_comb begin
    last_inner_s = (inner_q == (size_inner_q - CNT_ONE));
    last_outer_s = (outer_q == (size_outer_q - CNT_ONE));
  end

  // Next-state for indices, address accumulators and latched configuration
  always_comb begin
    inner_d        = inner_q;
    outer_d        = outer_q;
    base_d         = base_q;
    offset_d       = offset_q;
    size_inner_d   = size_inner_q;
    size_outer_d   = size_outer_q;
    inner_stride_d = inner_stride_q;
    outer_stride_d = outer_stride_q;
    if (clear) begin
      inner_d        = CNT_ZERO;
      outer_d        = CNT_ZERO;
      base_d         = CNT_ZERO;
      offset_d       = CNT_ZERO;
      size_inner_d   = size_inner;
      size_outer_d   = size_outer;
      inner_stride_d = inner_stride;
      outer_stride_d = outer_stride;
    end else if (step) begin
      if (last_inner_s) begin
        inner_d  = CNT_ZERO;
        offset_d = CNT_ZERO;
        outer_d  = outer_q + CNT_ONE;
        base_d   = base_q + outer_stride_q;
      end else begin
        inner_d  = inner_q + CNT_ONE;
        offset_d = offset_q + inner_stride_q;
      end
    end else begin
      inner_d = inner_q;
    end
    // Address wraps modulo 2^ADDRESS_SIZE by plain truncation
    address_d = ADDRESS_SIZE'(base_d + offset_d);
  end

  // Counter and address registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inner_q        <= CNT_ZERO;
      outer_q        <= CNT_ZERO;
      base_q         <= CNT_ZERO;
      offset_q       <= CNT_ZERO;
      size_inner_q   <= CNT_ZERO;
      size_outer_q   <= CNT_ZERO;
      inner_stride_q <= CNT_ZERO;
      outer_stride_q <= CNT_ZERO;
      address_q      <= {ADDRESS_SIZE{1'b0}};
    end else begin
      inner_q        <= inner_d;
      outer_q        <= outer_d;
      base_q         <= base_d;
      offset_q       <= offset_d;
      size_inner_q   <= size_inner_d;
      size_outer_q   <= size_outer_d;
      inner_stride_q <= inner_stride_d;
      outer_stride_q <= outer_stride_d;
      address_q      <= address_d;
    end
  end

  assign inner        = inner_q;
  assign outer        = outer_q;
  assign address      = address_q;
  assign last_inner   = last_inner_s;
  assign last_element = last_inner_s && last_outer_s;

endmodule

// File: rtl/dnc_matrix_streamer.sv
// ----------------------------------------------------------------------------
// dnc_matrix_streamer
// Upstream feeder for the DNC accelerator. Walks an L x X operand matrix held
// in a source memory one element at a time, presents each element on
// DATA_OUT with row/element strobes and waits for the accelerator's element
// acknowledge before moving on.
//
// Optional build macro DNC_MATRIX_STREAMER_TRANSPOSE_EN adds the TRANSPOSE
// input; when it is 1 on an accepted START the matrix is walked
// column-major (address = i*SIZE_X + j, column index outermost).
//
// Ports:
//   CLK, RST               clock, asynchronous active-low reset
//   START / READY          transfer request pulse / completion pulse
//   SIZE_L_IN, SIZE_X_IN   matrix dimensions, sampled on accepted START
//   MEM_ADDRESS, MEM_READ  source memory read request (data next cycle)
//   MEM_DATA               source memory read data
//   DATA_OUT               element to the accelerator
//   DATA_OUT_L_ENABLE      first element of each row (column if transposed)
//   DATA_OUT_X_ENABLE      every element
//   DATA_IN_L_ENABLE       accelerator row acknowledge (tallied only)
//   DATA_IN_X_ENABLE       accelerator element acknowledge
//   TRANSPOSE              column-major walk (macro builds only)
// ----------------------------------------------------------------------------
module dnc_matrix_streamer
  import dnc_matrix_streamer_pkg::*;
#(
  parameter int DATA_SIZE    = DNC_DATA_SIZE,
  parameter int CONTROL_SIZE = DNC_CONTROL_SIZE,
  parameter int ADDRESS_SIZE = DNC_ADDRESS_SIZE
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic [DATA_SIZE-1:0]    SIZE_L_IN,
  input  logic [DATA_SIZE-1:0]    SIZE_X_IN,
  output logic [ADDRESS_SIZE-1:0] MEM_ADDRESS,
  output logic                    MEM_READ,
  input  logic [DATA_SIZE-1:0]    MEM_DATA,
  output logic [DATA_SIZE-1:0]    DATA_OUT,
  output logic                    DATA_OUT_L_ENABLE,
  output logic                    DATA_OUT_X_ENABLE,
`ifdef DNC_MATRIX_STREAMER_TRANSPOSE_EN
  input  logic                    TRANSPOSE,
`endif
  input  logic                    DATA_IN_L_ENABLE,
  input  logic                    DATA_IN_X_ENABLE
);

  localparam logic [CONTROL_SIZE-1:0] CNT_ZERO = {CONTROL_SIZE{1'b0}};
  localparam logic [CONTROL_SIZE-1:0] CNT_ONE  = CONTROL_SIZE'(1'b1);

  state_e                  state_q, state_d;
  logic                    mem_read_q, mem_read_d;
  logic                    x_en_q, x_en_d;
  logic                    l_en_q, l_en_d;
  logic                    ready_q, ready_d;
  logic [DATA_SIZE-1:0]    data_out_q, data_out_d;
  logic [CONTROL_SIZE-1:0] row_ack_cnt_q, row_ack_cnt_d;

  logic                    transpose_s;
  logic                    size_zero_s;
  logic [CONTROL_SIZE-1:0] size_l_s, size_x_s;
  logic [CONTROL_SIZE-1:0] size_inner_s, size_outer_s;
  logic [CONTROL_SIZE-1:0] inner_stride_s, outer_stride_s;
  logic                    cnt_clear_s, cnt_step_s;
  logic [CONTROL_SIZE-1:0] inner_s, outer_s;
  logic [ADDRESS_SIZE-1:0] address_s;
  logic                    last_inner_s, last_element_s;
  logic                    unused_s;

`ifdef DNC_MATRIX_STREAMER_TRANSPOSE_EN
  assign transpose_s = TRANSPOSE;
`else
  assign transpose_s = 1'b0;
`endif

  // Map L/X onto the counter's inner/outer loops and address strides
  always_comb begin
    size_l_s    = CONTROL_SIZE'(SIZE_L_IN);
    size_x_s    = CONTROL_SIZE'(SIZE_X_IN);
    size_zero_s = (SIZE_L_IN == {DATA_SIZE{1'b0}}) || (SIZE_X_IN == {DATA_SIZE{1'b0}});
    if (transpose_s) begin
      size_inner_s   = size_l_s;
      size_outer_s   = size_x_s;
      inner_stride_s = size_x_s;
      outer_stride_s = CNT_ONE;
    end else begin
      size_inner_s   = size_x_s;
      size_outer_s   = size_l_s;
      inner_stride_s = CNT_ONE;
      outer_stride_s = size_x_s;
    end
  end

  dnc_matrix_streamer_counter #(
    .CONTROL_SIZE (CONTROL_SIZE),
    .ADDRESS_SIZE (ADDRESS_SIZE)
  ) u_counter (
    .clk          (CLK),
    .rst_n        (RST),
    .clear        (cnt_clear_s),
    .step         (cnt_step_s),
    .size_inner   (size_inner_s),
    .size_outer   (size_outer_s),
    .inner_stride (inner_stride_s),
    .outer_stride (outer_stride_s),
    .inner        (inner_s),
    .outer        (outer_s),
    .address      (address_s),
    .last_inner   (last_inner_s),
    .last_element (last_element_s)
  );

  // Sequencing FSM: next state and counter control
  always_comb begin
    state_d     = state_q;
    cnt_clear_s = 1'b0;
    cnt_step_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          if (size_zero_s) begin
            state_d = ST_DONE;
          end else begin
            state_d     = ST_FETCH;
            cnt_clear_s = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH:     state_d = ST_WAIT_DATA;
      ST_WAIT_DATA: state_d = ST_ISSUE;
      ST_ISSUE:     state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (DATA_IN_X_ENABLE) begin
          if (last_element_s) begin
            state_d = ST_DONE;
          end else begin
            state_d    = ST_FETCH;
            cnt_step_s = 1'b1;
          end
        end else begin
          state_d = ST_WAIT_ACK;
        end
      end
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Output register next-values; strobes line up with the state being entered
  always_comb begin
    mem_read_d = (state_d == ST_FETCH);
    x_en_d     = (state_d == ST_ISSUE);
    l_en_d     = (state_d == ST_ISSUE) && (inner_s == CNT_ZERO);
    ready_d    = (state_d == ST_DONE);
    // Memory data is valid the cycle after the read strobe, i.e. in WAIT_DATA
    if (state_q == ST_WAIT_DATA) begin
      data_out_d = MEM_DATA;
    end else begin
      data_out_d = data_out_q;
    end
    if (cnt_clear_s) begin
      row_ack_cnt_d = CNT_ZERO;
    end else if (DATA_IN_L_ENABLE) begin
      row_ack_cnt_d = row_ack_cnt_q + CNT_ONE;
    end else begin
      row_ack_cnt_d = row_ack_cnt_q;
    end
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= ST_IDLE;
      mem_read_q    <= 1'b0;
      x_en_q        <= 1'b0;
      l_en_q        <= 1'b0;
      ready_q       <= 1'b0;
      data_out_q    <= {DATA_SIZE{1'b0}};
      row_ack_cnt_q <= CNT_ZERO;
    end else begin
      state_q       <= state_d;
      mem_read_q    <= mem_read_d;
      x_en_q        <= x_en_d;
      l_en_q        <= l_en_d;
      ready_q       <= ready_d;
      data_out_q    <= data_out_d;
      row_ack_cnt_q <= row_ack_cnt_d;
    end
  end

  assign READY             = ready_q;
  assign MEM_READ          = mem_read_q;
  assign MEM_ADDRESS       = address_s;
  assign DATA_OUT          = data_out_q;
  assign DATA_OUT_X_ENABLE = x_en_q;
  assign DATA_OUT_L_ENABLE = l_en_q;

  // Row acks are only tallied and the outer index is not needed here
  assign unused_s = ^{outer_s, last_inner_s, row_ack_cnt_q};

endmodule

// File: tb/tb_dnc_matrix_streamer.sv
module tb_dnc_matrix_streamer;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0;
  logic        READY;
  logic [63:0] SIZE_L_IN = 64'd0;
  logic [63:0] SIZE_X_IN = 64'd0;
  logic [15:0] MEM_ADDRESS;
  logic        MEM_READ;
  logic [63:0] MEM_DATA = 64'd0;
  logic [63:0] DATA_OUT;
  logic        DATA_OUT_L_ENABLE;
  logic        DATA_OUT_X_ENABLE;
  logic        DATA_IN_L_ENABLE = 1'b0;
  logic        DATA_IN_X_ENABLE = 1'b0;
`ifdef DNC_MATRIX_STREAMER_TRANSPOSE_EN
  logic        TRANSPOSE = 1'b0;
`endif

  int          checks = 0;
  int          failures = 0;
  logic [63:0] mem_off = 64'd0;

  typedef struct {
    logic [63:0] data;
    logic        l_en;
  } elem_t;

  elem_t       exp_q[$];
  logic [15:0] addr_q[$];

  dnc_matrix_streamer dut (
    .CLK               (CLK),
    .RST               (RST),
    .START             (START),
    .READY             (READY),
    .SIZE_L_IN         (SIZE_L_IN),
    .SIZE_X_IN         (SIZE_X_IN),
    .MEM_ADDRESS       (MEM_ADDRESS),
    .MEM_READ          (MEM_READ),
    .MEM_DATA          (MEM_DATA),
    .DATA_OUT          (DATA_OUT),
    .DATA_OUT_L_ENABLE (DATA_OUT_L_ENABLE),
    .DATA_OUT_X_ENABLE (DATA_OUT_X_ENABLE),
`ifdef DNC_MATRIX_STREAMER_TRANSPOSE_EN
    .TRANSPOSE         (TRANSPOSE),
`endif
    .DATA_IN_L_ENABLE  (DATA_IN_L_ENABLE),
    .DATA_IN_X_ENABLE  (DATA_IN_X_ENABLE)
  );

  always #5 CLK = ~CLK;

  // Source memory model: word k holds k + mem_off, data one cycle after read
  always @(posedge CLK) begin
    if (MEM_READ) MEM_DATA <= {48'd0, MEM_ADDRESS} + mem_off;
  end

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One transfer: build expectations, drive START, act as accelerator.
  task automatic run_xfer(input int l, input int x, input bit tr, input int ack_dly,
                          input bit restart, input int abort_elem);
    int    cyc, ack_cyc, ack_timer, n_x, n_ready, tail;
    bit    pending, done, abort_now, last_l;
    logic [63:0] held;
    elem_t e;
    exp_q.delete();
    addr_q.delete();
    if (tr) begin
      for (int o = 0; o < x; o++)
        for (int i = 0; i < l; i++) begin
          addr_q.push_back(16'(i * x + o));
          exp_q.push_back('{data: 64'(i * x + o) + mem_off, l_en: (i == 0)});
        end
    end else begin
      for (int i = 0; i < l; i++)
        for (int o = 0; o < x; o++) begin
          addr_q.push_back(16'(i * x + o));
          exp_q.push_back('{data: 64'(i * x + o) + mem_off, l_en: (o == 0)});
        end
    end
    @(negedge CLK);
    SIZE_L_IN = 64'(l);
    SIZE_X_IN = 64'(x);
`ifdef DNC_MATRIX_STREAMER_TRANSPOSE_EN
    TRANSPOSE = tr;
`endif
    START = 1'b1;
    cyc = 0; ack_cyc = -100; ack_timer = -1; n_x = 0; n_ready = 0; tail = -1;
    pending = 1'b0; done = 1'b0; abort_now = 1'b0; last_l = 1'b0; held = 64'd0;
    while (!done) begin
      @(negedge CLK);
      cyc++;
      START = 1'b0;
      DATA_IN_X_ENABLE = 1'b0;
      DATA_IN_L_ENABLE = 1'b0;
      // Sizes change after acceptance; the transfer must not notice
      SIZE_L_IN = 64'd7;
      SIZE_X_IN = 64'd5;
      if (MEM_READ) begin
        if (addr_q.size() == 0) check_val("extra_read", 64'd1, 64'd0);
        else check_val("mem_addr", {48'd0, MEM_ADDRESS}, {48'd0, addr_q.pop_front()});
      end
      if (pending && !DATA_OUT_X_ENABLE) check_val("data_hold", DATA_OUT, held);
      if (abort_now) begin
        RST = 1'b0;
        #1;
        check_val("abort_outs", {DATA_OUT_X_ENABLE, DATA_OUT_L_ENABLE, MEM_READ, READY},
                  64'd0);
        check_val("abort_data", DATA_OUT, 64'd0);
        check_val("abort_addr", {48'd0, MEM_ADDRESS}, 64'd0);
        for (int k = 0; k < 3; k++) begin
          @(negedge CLK);
          check_val("abort_ready", {63'd0, READY}, 64'd0);
        end
        RST = 1'b1;
        exp_q.delete();
        addr_q.delete();
        done = 1'b1;
      end else begin
        if (ack_timer > 0) begin
          ack_timer--;
          if (ack_timer == 0) begin
            DATA_IN_X_ENABLE = 1'b1;
            DATA_IN_L_ENABLE = last_l;
            ack_cyc = cyc;
            ack_timer = -1;
          end
        end
        if (tail > 0) begin
          tail--;
          if (tail == 0) done = 1'b1;
        end
        if (DATA_OUT_X_ENABLE) begin
          n_x++;
          if (n_x == 1) check_val("first_x_lat", 64'(cyc), 64'd3);
          if (exp_q.size() == 0) check_val("extra_elem", 64'd1, 64'd0);
          else begin
            e = exp_q.pop_front();
            check_val("data_out", DATA_OUT, e.data);
            check_val("l_enable", {63'd0, DATA_OUT_L_ENABLE}, {63'd0, e.l_en});
            last_l = e.l_en;
          end
          held = DATA_OUT;
          pending = 1'b1;
          ack_timer = ack_dly;
          if (restart && n_x == 2) START = 1'b1;
          if (abort_elem != 0 && n_x == abort_elem) begin
            ack_timer = -1;
            abort_now = 1'b1;
          end
        end else if (DATA_OUT_L_ENABLE) begin
          check_val("l_without_x", {63'd0, DATA_OUT_L_ENABLE}, 64'd0);
        end
        if (READY) begin
          n_ready++;
          if (l == 0 || x == 0) check_val("zero_ready_lat", 64'(cyc), 64'd1);
          else check_val("ready_lat", 64'(cyc - ack_cyc), 64'd1);
          // START landing on the DONE cycle must be ignored
          if (restart) START = 1'b1;
          tail = 5;
        end
        if (cyc > 500) begin
          check_val("timeout", 64'd1, 64'd0);
          done = 1'b1;
        end
      end
    end
    if (abort_elem == 0) begin
      check_val("ready_count", 64'(n_ready), 64'd1);
      check_val("elem_count", 64'(n_x), 64'(l * x));
      check_val("elems_left", 64'(exp_q.size()), 64'd0);
      check_val("reads_left", 64'(addr_q.size()), 64'd0);
    end else begin
      check_val("abort_ready_count", 64'(n_ready), 64'd0);
    end
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    check_val("rst_strobes", {60'd0, DATA_OUT_X_ENABLE, DATA_OUT_L_ENABLE, MEM_READ, READY},
              64'd0);
    check_val("rst_data", DATA_OUT, 64'd0);
    check_val("rst_addr", {48'd0, MEM_ADDRESS}, 64'd0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    mem_off = 64'd10;
    run_xfer(2, 3, 1'b0, 1, 1'b0, 0);   // 10..15, L on 10 and 13
    run_xfer(0, 5, 1'b0, 1, 1'b0, 0);   // empty: READY only
    run_xfer(1, 1, 1'b0, 7, 1'b0, 0);   // slow ack, held data
    run_xfer(2, 2, 1'b0, 1, 1'b1, 0);   // START repulsed mid-transfer and in DONE
    mem_off = 64'd0;
    run_xfer(2, 3, 1'b0, 1, 1'b0, 3);   // reset during 3rd element's ack wait
    run_xfer(2, 3, 1'b0, 2, 1'b0, 0);   // restarts from address 0
`ifdef DNC_MATRIX_STREAMER_TRANSPOSE_EN
    run_xfer(2, 3, 1'b1, 1, 1'b0, 0);   // addresses 0,3,1,4,2,5
    run_xfer(2, 3, 1'b0, 1, 1'b0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
